// File: rtl/bank_power_sequencer_if.sv
// Power-manager <-> bank sequencer bundle: level requests in, bank enables/status out.
// With PWR_SEQ_STATS_EN defined the bundle also carries wake and stall counters.
interface bank_power_sequencer_if #(
  parameter int NUM_BANKS = 16
);
  logic [NUM_BANKS-1:0] target_mask;
  logic                 sleep_req;
  logic [NUM_BANKS-1:0] bank_en;
  logic [NUM_BANKS-1:0] bank_ready;
  logic                 all_ready;
  logic                 busy;

`ifdef PWR_SEQ_STATS_EN
  logic [31:0] stat_wakes;
  logic [31:0] stat_stall;

  modport master (
    output target_mask, sleep_req,
    input  bank_en, bank_ready, all_ready, busy, stat_wakes, stat_stall
  );
  modport slave (
    input  target_mask, sleep_req,
    output bank_en, bank_ready, all_ready, busy, stat_wakes, stat_stall
  );
`else
  modport master (
    output target_mask, sleep_req,
    input  bank_en, bank_ready, all_ready, busy
  );
  modport slave (
    input  target_mask, sleep_req,
    output bank_en, bank_ready, all_ready, busy
  );
`endif
endinterface

// File: rtl/bank_power_sequencer.sv
// Staggered one-bank-at-a-time power-up (WAKE_CYCLES per bank), hysteresis power-down; no backpressure.
// Optional PWR_SEQ_STATS_EN adds saturating wake/stall counters.
module bank_power_sequencer #(
  parameter int NUM_BANKS    = 16,
  parameter int WAKE_CYCLES  = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bank_power_sequencer_if.slave  pm
);

  localparam int IW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAKE_LOAD = WW'(WAKE_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LOAD = TW'(IDLE_TIMEOUT - 1);

  typedef logic [NUM_BANKS-1:0] mask_t;
  typedef enum logic {S_IDLE, S_WAKE} state_t;

  state_t        state_q, state_d;
  mask_t         bank_en_q, bank_ready_q, target_q;
  logic [WW-1:0] wake_cnt_q, wake_cnt_d;
  logic [IW-1:0] wake_idx_q, wake_idx_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;

  mask_t         eff_target, up_pend, wake_oh, drop_mask, down_mask;
  mask_t         up_set, rdy_set;
  logic [IW-1:0] low_idx;
  logic          timer_fire;
  logic          all_ready_c;

  always_comb begin
    eff_target = pm.sleep_req ? '0 : pm.target_mask;
    up_pend    = eff_target & ~bank_en_q;
    low_idx    = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (up_pend[i]) low_idx = IW'(i);
    end
    // The bank currently waking is never dropped; it finishes first.
    wake_oh   = (state_q == S_WAKE) ? (mask_t'(1) << wake_idx_q) : '0;
    drop_mask = bank_en_q & ~eff_target & ~wake_oh;
  end

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    timer_fire = 1'b0;
    if (drop_mask == '0 || pm.target_mask != target_q) begin
      idle_cnt_d = IDLE_LOAD;
    end else if (idle_cnt_q != '0) begin
      idle_cnt_d = idle_cnt_q - TW'(1);
    end else begin
      timer_fire = 1'b1;
      idle_cnt_d = IDLE_LOAD;
    end
    down_mask = (pm.sleep_req || timer_fire) ? drop_mask : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bank_en_q    <= '0;
      bank_ready_q <= '0;
      target_q     <= '0;
      wake_cnt_q   <= '0;
      wake_idx_q   <= '0;
      idle_cnt_q   <= IDLE_LOAD;
    end else begin
      state_q      <= state_d;
      // up_set lies inside eff_target and down_mask outside it, so they never collide.
      bank_en_q    <= (bank_en_q | up_set) & ~down_mask;
      bank_ready_q <= (bank_ready_q | rdy_set) & ~down_mask;
      target_q     <= pm.target_mask;
      wake_cnt_q   <= wake_cnt_d;
      wake_idx_q   <= wake_idx_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (up_pend != '0) state_d = S_WAKE;
      S_WAKE:  if (wake_cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    up_set     = '0;
    rdy_set    = '0;
    wake_cnt_d = wake_cnt_q;
    wake_idx_d = wake_idx_q;
    case (state_q)
      S_IDLE: begin
        if (up_pend != '0) begin
          up_set     = mask_t'(1) << low_idx;
          wake_cnt_d = WAKE_LOAD;
          wake_idx_d = low_idx;
        end
      end
      S_WAKE: begin
        if (wake_cnt_q == '0) rdy_set = mask_t'(1) << wake_idx_q;
        else                  wake_cnt_d = wake_cnt_q - WW'(1);
      end
      default: ;
    endcase
  end

  assign all_ready_c   = ((pm.target_mask & ~bank_ready_q) == '0) && !pm.sleep_req;
  assign pm.bank_en    = bank_en_q;
  assign pm.bank_ready = bank_ready_q;
  assign pm.all_ready  = all_ready_c;
  assign pm.busy       = (state_q == S_WAKE) || (up_pend != '0);

`ifdef PWR_SEQ_STATS_EN
  logic [31:0] stat_wakes_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_wakes_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (up_set != '0 && stat_wakes_q != '1)
        stat_wakes_q <= stat_wakes_q + 32'd1;
      if (pm.target_mask != '0 && !all_ready_c && stat_stall_q != '1)
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign pm.stat_wakes = stat_wakes_q;
  assign pm.stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_bank_power_sequencer.sv
// Scoreboard bench for bank_power_sequencer (16 banks, wake 4, idle timeout 8).
// Expectations are queued per edge offset and checked 1ns after each rising edge.
module tb_bank_power_sequencer;

  localparam int K_EN = 0, K_RDY = 1, K_ALL = 2, K_BUSY = 3, K_WAKES = 4, K_STALL = 5;

  logic clk = 1'b0;
  logic rst_n;

  bank_power_sequencer_if #(.NUM_BANKS(16)) pm_if ();

  bank_power_sequencer #(
    .NUM_BANKS   (16),
    .WAKE_CYCLES (4),
    .IDLE_TIMEOUT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pm   (pm_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;
  int   base     = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    logic [31:0] v;
    v = '0;
    case (kind)
      K_EN:    v = {16'h0, pm_if.bank_en};
      K_RDY:   v = {16'h0, pm_if.bank_ready};
      K_ALL:   v = {31'h0, pm_if.all_ready};
      K_BUSY:  v = {31'h0, pm_if.busy};
`ifdef PWR_SEQ_STATS_EN
      K_WAKES: v = pm_if.stat_wakes;
      K_STALL: v = pm_if.stat_stall;
`endif
      default: v = 32'hdead_beef;
    endcase
    return v;
  endfunction

  task automatic expect_at(input int k, input int kind, input logic [31:0] val, input string tag);
    exp_t e;
    e.cyc  = base + k;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int   i;
    exp_t e;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].cyc <= edge_n) begin
        e = sb_q[i];
        sb_q.delete(i);
        check_val(e.tag, observe(e.kind), e.val);
      end else begin
        i++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  // Fresh power-up of target 0x0003 from all-off: per-bank period is WAKE_CYCLES+1.
  task automatic push_seq(input string p);
    expect_at(1,  K_EN,   32'h1, {p, "_en1"});
    expect_at(1,  K_RDY,  32'h0, {p, "_rdy1"});
    expect_at(4,  K_EN,   32'h1, {p, "_en4"});
    expect_at(4,  K_RDY,  32'h0, {p, "_rdy4"});
    expect_at(5,  K_EN,   32'h1, {p, "_en5"});
    expect_at(5,  K_RDY,  32'h1, {p, "_rdy5"});
    expect_at(5,  K_BUSY, 32'h1, {p, "_busy5"});
    expect_at(5,  K_ALL,  32'h0, {p, "_all5"});
    expect_at(6,  K_EN,   32'h3, {p, "_en6"});
    expect_at(6,  K_RDY,  32'h1, {p, "_rdy6"});
    expect_at(9,  K_RDY,  32'h1, {p, "_rdy9"});
    expect_at(9,  K_BUSY, 32'h1, {p, "_busy9"});
    expect_at(10, K_EN,   32'h3, {p, "_en10"});
    expect_at(10, K_RDY,  32'h3, {p, "_rdy10"});
    expect_at(10, K_ALL,  32'h1, {p, "_all10"});
    expect_at(10, K_BUSY, 32'h0, {p, "_busy10"});
  endtask

  initial begin
    rst_n                = 1'b0;
    pm_if.target_mask    = '0;
    pm_if.sleep_req      = 1'b0;
    repeat (3) tick();

    // Reset state
    base = edge_n;
    expect_at(0, K_EN,   32'h0, "rst_en");
    expect_at(0, K_RDY,  32'h0, "rst_rdy");
    expect_at(0, K_ALL,  32'h1, "rst_all");
    expect_at(0, K_BUSY, 32'h0, "rst_busy");
`ifdef PWR_SEQ_STATS_EN
    expect_at(0, K_WAKES, 32'd0, "rst_wakes");
    expect_at(0, K_STALL, 32'd0, "rst_stall");
`endif
    settle();

    // Staggered power-up of banks 0 and 1
    rst_n             = 1'b1;
    pm_if.target_mask = 16'h0003;
    base              = edge_n;
    push_seq("t1");
`ifdef PWR_SEQ_STATS_EN
    expect_at(10, K_STALL, 32'd10, "t1_stall");
`endif
    repeat (12) tick();

    // Hysteresis drop of bank 1
    pm_if.target_mask = 16'h0001;
    base              = edge_n;
    expect_at(1, K_ALL,  32'h1, "t2_all1");
    expect_at(1, K_BUSY, 32'h0, "t2_busy1");
    expect_at(8, K_EN,   32'h3, "t2_en8");
    expect_at(8, K_RDY,  32'h3, "t2_rdy8");
    expect_at(9, K_EN,   32'h1, "t2_en9");
    expect_at(9, K_RDY,  32'h1, "t2_rdy9");
    repeat (11) tick();

    // Swap to bank 8: new wake overlaps old bank's hysteresis
    pm_if.target_mask = 16'h0100;
    base              = edge_n;
    expect_at(1, K_EN,   32'h0101, "t6_en1");
    expect_at(1, K_RDY,  32'h0001, "t6_rdy1");
    expect_at(4, K_RDY,  32'h0001, "t6_rdy4");
    expect_at(4, K_ALL,  32'h0,    "t6_all4");
    expect_at(5, K_RDY,  32'h0101, "t6_rdy5");
    expect_at(5, K_ALL,  32'h1,    "t6_all5");
    expect_at(5, K_BUSY, 32'h0,    "t6_busy5");
    expect_at(8, K_EN,   32'h0101, "t6_en8");
    expect_at(9, K_EN,   32'h0100, "t6_en9");
    expect_at(9, K_RDY,  32'h0100, "t6_rdy9");
`ifdef PWR_SEQ_STATS_EN
    expect_at(9, K_WAKES, 32'd3,  "t6_wakes");
    expect_at(9, K_STALL, 32'd15, "t6_stall");
`endif
    repeat (9) tick();

    // Back to 0x0003 steady
    pm_if.target_mask = 16'h0003;
    base              = edge_n;
    expect_at(20, K_EN,  32'h3, "t3s_en");
    expect_at(20, K_RDY, 32'h3, "t3s_rdy");
    expect_at(20, K_ALL, 32'h1, "t3s_all");
    repeat (20) tick();

    // Short dip to 0x0001 must not power anything down
    pm_if.target_mask = 16'h0001;
    base              = edge_n;
    expect_at(5, K_EN,  32'h3, "t3_en5");
    expect_at(5, K_RDY, 32'h3, "t3_rdy5");
    repeat (5) tick();
    pm_if.target_mask = 16'h0003;
    expect_at(5, K_ALL, 32'h1, "t3_all_back");
    settle();
    expect_at(17, K_EN,   32'h3, "t3_en17");
    expect_at(17, K_RDY,  32'h3, "t3_rdy17");
    expect_at(17, K_BUSY, 32'h0, "t3_busy17");
    repeat (12) tick();

    // sleep_req while bank 2 is waking
    pm_if.target_mask = 16'h0007;
    base              = edge_n;
    expect_at(3, K_EN,  32'h7, "t4_en3");
    expect_at(3, K_RDY, 32'h3, "t4_rdy3");
    repeat (3) tick();
    pm_if.sleep_req = 1'b1;
    expect_at(3, K_ALL, 32'h0, "t4_all_sleep");
    settle();
    expect_at(4, K_EN,   32'h4, "t4_en4");
    expect_at(4, K_RDY,  32'h0, "t4_rdy4");
    expect_at(4, K_ALL,  32'h0, "t4_all4");
    expect_at(4, K_BUSY, 32'h1, "t4_busy4");
    expect_at(5, K_EN,   32'h4, "t4_en5");
    expect_at(5, K_RDY,  32'h4, "t4_rdy5");
    expect_at(5, K_ALL,  32'h0, "t4_all5");
    expect_at(5, K_BUSY, 32'h0, "t4_busy5");
    expect_at(6, K_EN,   32'h0, "t4_en6");
    expect_at(6, K_RDY,  32'h0, "t4_rdy6");
    repeat (3) tick();
    pm_if.sleep_req = 1'b0;
    expect_at(6, K_BUSY, 32'h1, "t4_busy_wake");
    settle();
    expect_at(7,  K_EN,  32'h1, "t4_en7");
    expect_at(21, K_EN,  32'h7, "t4_en21");
    expect_at(21, K_RDY, 32'h7, "t4_rdy21");
    expect_at(21, K_ALL, 32'h1, "t4_all21");
    repeat (15) tick();

    // Reset in the middle of bank 1's wake
    rst_n             = 1'b0;
    pm_if.target_mask = 16'h0003;
    tick();
    rst_n = 1'b1;
    base  = edge_n;
    expect_at(7, K_EN,  32'h3, "t5_en7");
    expect_at(7, K_RDY, 32'h1, "t5_rdy7");
    repeat (7) tick();
    rst_n = 1'b0;
    expect_at(8, K_EN,   32'h0, "t5_rst_en");
    expect_at(8, K_RDY,  32'h0, "t5_rst_rdy");
    expect_at(8, K_ALL,  32'h0, "t5_rst_all");
    expect_at(8, K_BUSY, 32'h1, "t5_rst_busy");
    tick();
    rst_n = 1'b1;
    base  = edge_n;
    push_seq("t5");
    repeat (12) tick();

    check_val("sb_leftover", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
